muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_negate.sv | 13 +
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation encoding,
// controller states and the default datapath width.
package muldiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      OP_MULT  = 2'b00,
      OP_MULTU = 2'b01,
      OP_DIV   = 2'b10,
      OP_DIVU  = 2'b11
   } opEnum_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and for
// restoring the sign of products, quotients and remainders.
module muldiv_negate #(
   parameter int WIDTH = 32
) (
   input  logic             neg_i,
   input  logic [WIDTH-1:0] value_i,
   output logic [WIDTH-1:0] result_o
);

   assign result_o = neg_i ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit, one bit per cycle.
// Signed MULT/DIV are built only when MULDIV_SIGNED_EN is defined; otherwise they act as MULTU/DIVU.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state_q;
   logic [CNT_W-1:0]   count_q;
   logic [2*WIDTH-1:0] work_q;
   logic [WIDTH-1:0]   divisor_q;
   logic               isDiv_q;
   logic               dbzPend_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;
   logic               dbz_q;

   opEnum_t            opSel;
   logic               opIsDiv;
   logic               signA;
   logic               signB;
   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;

   logic [WIDTH:0]     multSum;
   logic [2*WIDTH-1:0] multNext;
   logic [WIDTH:0]     divShift;
   logic [WIDTH:0]     divDiff;
   logic               divGe;
   logic [WIDTH-1:0]   divRem;
   logic [2*WIDTH-1:0] divNext;
   logic [2*WIDTH-1:0] fixResult;

   assign opSel   = opEnum_t'(op);
   assign opIsDiv = (opSel == OP_DIV) || (opSel == OP_DIVU);

`ifdef MULDIV_SIGNED_EN
   logic               opSigned;
   logic               resSign_q;
   logic               remSign_q;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   remFix;
   logic [WIDTH-1:0]   quoFix;

   assign opSigned = (opSel == OP_MULT) || (opSel == OP_DIV);
   assign signA    = opSigned & a[WIDTH-1];
   assign signB    = opSigned & b[WIDTH-1];

   muldiv_negate #(.WIDTH(2*WIDTH)) uNegProd (
      .neg_i(resSign_q), .value_i(work_q), .result_o(prodFix)
   );
   muldiv_negate #(.WIDTH(WIDTH)) uNegRem (
      .neg_i(remSign_q), .value_i(work_q[2*WIDTH-1:WIDTH]), .result_o(remFix)
   );
   muldiv_negate #(.WIDTH(WIDTH)) uNegQuo (
      .neg_i(resSign_q), .value_i(work_q[WIDTH-1:0]), .result_o(quoFix)
   );

   assign fixResult = isDiv_q ? {remFix, quoFix} : prodFix;
`else
   assign signA     = 1'b0;
   assign signB     = 1'b0;
   assign fixResult = work_q;
`endif

   muldiv_negate #(.WIDTH(WIDTH)) uMagA (
      .neg_i(signA), .value_i(a), .result_o(magA)
   );
   muldiv_negate #(.WIDTH(WIDTH)) uMagB (
      .neg_i(signB), .value_i(b), .result_o(magB)
   );

   // Multiply: work_q holds {partial product, remaining multiplier bits}.
   assign multSum  = {1'b0, work_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (work_q[0] ? divisor_q : {WIDTH{1'b0}})};
   assign multNext = {multSum, work_q[WIDTH-1:1]};

   // Divide: work_q holds {partial remainder, dividend bits shifting into quotient}.
   // A borrow out of the (WIDTH+1)-bit subtract means the trial step is restored.
   assign divShift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
   assign divDiff  = divShift - {1'b0, divisor_q};
   assign divGe    = ~divDiff[WIDTH];
   assign divRem   = divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
   assign divNext  = {divRem, work_q[WIDTH-2:0], divGe};

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         work_q    <= '0;
         divisor_q <= '0;
         isDiv_q   <= 1'b0;
         dbzPend_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
         resSign_q <= 1'b0;
         remSign_q <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  busy_q  <= 1'b1;
                  dbz_q   <= 1'b0;
                  isDiv_q <= opIsDiv;
                  count_q <= '0;
`ifdef MULDIV_SIGNED_EN
                  resSign_q <= signA ^ signB;
                  remSign_q <= signA;
`endif
                  if (opIsDiv && (b == '0)) begin
                     work_q    <= {a, {WIDTH{1'b1}}};
                     dbzPend_q <= 1'b1;
                     state_q   <= S_DONE;
                  end else begin
                     work_q    <= {{WIDTH{1'b0}}, (opIsDiv ? magA : magB)};
                     divisor_q <= opIsDiv ? magB : magA;
                     dbzPend_q <= 1'b0;
                     state_q   <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               work_q  <= isDiv_q ? divNext : multNext;
               count_q <= count_q + CNT_W'(1);
               if (count_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               work_q  <= fixResult;
               state_q <= S_DONE;
            end
            S_DONE: begin
               hi_q    <= work_q[2*WIDTH-1:WIDTH];
               lo_q    <= work_q[WIDTH-1:0];
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               dbz_q   <= dbzPend_q;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Table-driven bench for muldiv_unit at WIDTH=32; expected signed results follow
// MULDIV_SIGNED_EN, otherwise MULT/DIV vectors expect unsigned behaviour.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int WIDTH    = 32;
   localparam int LAT      = WIDTH + 2;
   localparam int MAX_WAIT = 100;
   localparam int NVEC     = 13;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic [1:0]       op    = 2'b00;
   logic [WIDTH-1:0] a     = '0;
   logic [WIDTH-1:0] b     = '0;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             div_by_zero;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      opEnum_t          op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] expHi;
      logic [WIDTH-1:0] expLo;
      logic             expDbz;
      int               expLat;
   } vec_t;

   vec_t vecs [NVEC];

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
   endtask

   // Issues one request and waits (bounded) for its done pulse; latency -1 means none came.
   task automatic applyStimulus(input opEnum_t opIn, input logic [WIDTH-1:0] aIn,
                                input logic [WIDTH-1:0] bIn,
                                output logic [WIDTH-1:0] hiOut, output logic [WIDTH-1:0] loOut,
                                output logic dbzOut, output logic busyOut, output int latency);
      @(negedge clock);
      start = 1'b1; op = opIn; a = aIn; b = bIn;
      @(posedge clock); #1;
      start = 1'b0;
      checkOutput("busy after accept", {63'd0, busy}, 64'd1);
      latency = -1;
      for (int k = 1; k <= MAX_WAIT; k++) begin
         @(posedge clock); #1;
         if (done) begin
            latency = k;
            break;
         end
      end
      hiOut = hi; loOut = lo; dbzOut = div_by_zero; busyOut = busy;
   endtask

   initial begin
      logic [WIDTH-1:0] gotHi, gotLo;
      logic             gotDbz, gotBusy;
      int               gotLat, doneCount, doneAt;

      vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT};
      vecs[1]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 1};
      vecs[2]  = '{OP_MULTU, 32'd7,        32'd9,        32'd0,        32'd63,       1'b0, LAT};
      vecs[3]  = '{OP_DIVU,  32'd9,        32'd4,        32'd1,        32'd2,        1'b0, LAT};
      vecs[4]  = '{OP_MULT,  32'd12345,    32'd0,        32'd0,        32'd0,        1'b0, LAT};
      vecs[5]  = '{OP_DIV,   32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1, 1};
      vecs[6]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0, LAT};
`ifdef MULDIV_SIGNED_EN
      vecs[7]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, LAT};
      vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, LAT};
      vecs[9]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, LAT};
      vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, LAT};
      vecs[11] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, LAT};
      vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1'b0, LAT};
`else
      vecs[7]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'd4,        32'hFFFFFFF1, 1'b0, LAT};
      vecs[8]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'd1,        32'h7FFFFFFC, 1'b0, LAT};
      vecs[9]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, LAT};
      vecs[10] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, LAT};
      vecs[11] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd7,        32'd0,        1'b0, LAT};
      vecs[12] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd0,        1'b0, LAT};
`endif

      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checkOutput("reset hi",   {32'd0, hi}, 64'd0);
      checkOutput("reset lo",   {32'd0, lo}, 64'd0);
      checkOutput("reset busy", {63'd0, busy}, 64'd0);
      checkOutput("reset done", {63'd0, done}, 64'd0);
      checkOutput("reset dbz",  {63'd0, div_by_zero}, 64'd0);
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, gotHi, gotLo, gotDbz, gotBusy, gotLat);
         checkOutput($sformatf("v%0d latency", i), 64'(gotLat), 64'(vecs[i].expLat));
         checkOutput($sformatf("v%0d hi", i), {32'd0, gotHi}, {32'd0, vecs[i].expHi});
         checkOutput($sformatf("v%0d lo", i), {32'd0, gotLo}, {32'd0, vecs[i].expLo});
         checkOutput($sformatf("v%0d dbz", i), {63'd0, gotDbz}, {63'd0, vecs[i].expDbz});
         checkOutput($sformatf("v%0d busy at done", i), {63'd0, gotBusy}, 64'd0);
      end

      // Results hold between done pulses; done stays a single-cycle pulse.
      repeat (5) @(posedge clock);
      #1;
      checkOutput("hold hi",   {32'd0, hi}, {32'd0, vecs[NVEC-1].expHi});
      checkOutput("hold lo",   {32'd0, lo}, {32'd0, vecs[NVEC-1].expLo});
      checkOutput("hold done", {63'd0, done}, 64'd0);

      // div_by_zero persists until the next acceptance, then clears.
      applyStimulus(OP_DIVU, 32'd55, 32'd0, gotHi, gotLo, gotDbz, gotBusy, gotLat);
      repeat (3) @(posedge clock);
      #1;
      checkOutput("dbz held", {63'd0, div_by_zero}, 64'd1);
      applyStimulus(OP_MULTU, 32'd2, 32'd3, gotHi, gotLo, gotDbz, gotBusy, gotLat);
      checkOutput("dbz cleared", {63'd0, gotDbz}, 64'd0);
      checkOutput("mul 2x3 lo", {32'd0, gotLo}, 64'd6);

      // Starts during CALC and DONE are ignored; operand changes mid-run have no effect.
      @(negedge clock);
      start = 1'b1; op = OP_MULTU; a = 32'd7; b = 32'd9;
      @(posedge clock); #1;
      start = 1'b0;
      doneCount = 0; doneAt = -1; gotLo = '0; gotHi = '1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clock);
         if (i == 5 || i == 20 || i == 34) begin
            start = 1'b1; op = OP_MULTU; a = 32'd100; b = 32'd100;
         end else begin
            start = 1'b0;
         end
         if (i == 10) begin
            op = OP_DIVU; a = 32'hDEADBEEF; b = 32'h12345678;
         end
         @(posedge clock); #1;
         if (done) begin
            doneCount++; doneAt = i; gotLo = lo; gotHi = hi;
         end
      end
      start = 1'b0;
      checkOutput("ignored starts done count", 64'(doneCount), 64'd1);
      checkOutput("ignored starts done cycle", 64'(doneAt), 64'(LAT));
      checkOutput("ignored starts lo", {32'd0, gotLo}, 64'd63);
      checkOutput("ignored starts hi", {32'd0, gotHi}, 64'd0);
      checkOutput("ignored starts idle", {63'd0, busy}, 64'd0);

      // Reset mid-divide aborts it; a start right after release is accepted.
      @(negedge clock);
      start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd7;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("abort hi",   {32'd0, hi}, 64'd0);
      checkOutput("abort lo",   {32'd0, lo}, 64'd0);
      checkOutput("abort busy", {63'd0, busy}, 64'd0);
      checkOutput("abort done", {63'd0, done}, 64'd0);
      @(negedge clock);
      reset = 1'b1; start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd4;
      @(posedge clock); #1;
      start = 1'b0;
      checkOutput("restart busy", {63'd0, busy}, 64'd1);
      doneCount = 0; doneAt = -1; gotLo = '0; gotHi = '0;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clock); #1;
         if (done) begin
            doneCount++;
            if (doneAt < 0) begin
               doneAt = i; gotLo = lo; gotHi = hi;
            end
         end
      end
      checkOutput("restart done count", 64'(doneCount), 64'd1);
      checkOutput("restart latency", 64'(doneAt), 64'(LAT));
      checkOutput("restart lo", {32'd0, gotLo}, 64'd2);
      checkOutput("restart hi", {32'd0, gotHi}, 64'd1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
